reg_scoreboard: RTL and testbench

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard.sv | 105 ++++++++++
 tb/tb_reg_scoreboard.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register-file pending-write scoreboard: tracks outstanding writes per architectural
// register, stalls issue on source hazards or saturated destinations, and flags stray writebacks.
module reg_scoreboard #(
    parameter int MAX_PEND = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iss_valid,
    output logic        iss_ready,
    input  logic [4:0]  iss_rd,
    input  logic        iss_rd_we,
    input  logic [4:0]  iss_rs,
    input  logic [4:0]  iss_rt,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        flush,
    output logic [31:0] busy_vec,
    output logic [6:0]  pend_total,
    output logic        wb_err
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_PEND);

    logic [1:0]  cnt_r [32];
    logic [6:0]  pend_total_r;
    logic        wb_err_r;
    logic [31:0] busy_s;
    logic [6:0]  sum_s;
    logic        fire_s;
    logic        rd_full_s;
    logic        wb_stray_s;

    // Busy decode and running total, both taken from the registered counts only
    always_comb begin
        busy_s = 32'd0;
        sum_s  = 7'd0;
        for (int r = 1; r < 32; r++) begin
            busy_s[r] = (cnt_r[r] != 2'd0);
            sum_s     = sum_s + 7'(cnt_r[r]);
        end
    end

    // Issue handshake; writeback of the same cycle is deliberately not forwarded
    always_comb begin
        rd_full_s  = iss_rd_we && (iss_rd != 5'd0) && (cnt_r[iss_rd] == MAX_CNT);
        iss_ready  = !flush && !busy_s[iss_rs] && !busy_s[iss_rt] && !rd_full_s;
        fire_s     = iss_valid && iss_ready;
        wb_stray_s = wb_valid && (wb_rd != 5'd0) && (cnt_r[wb_rd] == 2'd0);
    end

    // Per-register pending counters; a matching increment and decrement cancel out
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < 32; r++) begin
                cnt_r[r] <= 2'd0;
            end
        end else if (flush) begin
            for (int r = 0; r < 32; r++) begin
                cnt_r[r] <= 2'd0;
            end
        end else begin
            cnt_r[0] <= 2'd0;
            for (int r = 1; r < 32; r++) begin
                logic inc_v;
                logic dec_v;
                inc_v = fire_s && iss_rd_we && (iss_rd == 5'(r)) && (cnt_r[r] < MAX_CNT);
                dec_v = wb_valid && (wb_rd == 5'(r)) && (cnt_r[r] != 2'd0);
                if (inc_v && !dec_v) begin
                    cnt_r[r] <= cnt_r[r] + 2'd1;
                end else if (dec_v && !inc_v) begin
                    cnt_r[r] <= cnt_r[r] - 2'd1;
                end else begin
                    cnt_r[r] <= cnt_r[r];
                end
            end
        end
    end

    // Total lags the counts by one edge, except flush which zeroes it directly
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_total_r <= 7'd0;
        end else if (flush) begin
            pend_total_r <= 7'd0;
        end else begin
            pend_total_r <= sum_s;
        end
    end

    // Sticky stray-writeback flag; only reset clears it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wb_err_r <= 1'b0;
        end else if (!flush && wb_stray_s) begin
            wb_err_r <= 1'b1;
        end else begin
            wb_err_r <= wb_err_r;
        end
    end

    assign busy_vec   = busy_s;
    assign pend_total = pend_total_r;
    assign wb_err     = wb_err_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: stimulus pushes per-cycle expectations into a queue,
// an independent monitor pops and compares them at each falling edge.
module tb_reg_scoreboard;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        iss_valid = 1'b0;
    logic        iss_ready;
    logic [4:0]  iss_rd = 5'd0;
    logic        iss_rd_we = 1'b0;
    logic [4:0]  iss_rs = 5'd0;
    logic [4:0]  iss_rt = 5'd0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic        flush = 1'b0;
    logic [31:0] busy_vec;
    logic [6:0]  pend_total;
    logic        wb_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string  name;
        longint busy;
        int     pend;
        int     err;
        int     rdy;
    } exp_t;

    exp_t q[$];
    exp_t cur;

    reg_scoreboard #(.MAX_PEND(3)) dut (
        .clock(clock), .reset(reset),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_rd(iss_rd), .iss_rd_we(iss_rd_we), .iss_rs(iss_rs), .iss_rt(iss_rt),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .busy_vec(busy_vec), .pend_total(pend_total), .wb_err(wb_err)
    );

    always #5 clock = ~clock;

    task automatic cmp(input string nm, input string fld, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, req);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle; -1 marks a field not checked
    always @(negedge clock) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
            if (cur.busy >= 0) cmp(cur.name, "busy_vec", longint'(busy_vec), cur.busy);
            if (cur.pend >= 0) cmp(cur.name, "pend_total", longint'(pend_total), longint'(cur.pend));
            if (cur.err >= 0)  cmp(cur.name, "wb_err", longint'(wb_err), longint'(cur.err));
            if (cur.rdy >= 0)  cmp(cur.name, "iss_ready", longint'(iss_ready), longint'(cur.rdy));
        end
    end

    task automatic drive(input logic v, input logic [4:0] rd, input logic we,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic wv, input logic [4:0] wrd, input logic fl);
        @(posedge clock);
        #1;
        iss_valid = v;  iss_rd = rd;  iss_rd_we = we;  iss_rs = rs;  iss_rt = rt;
        wb_valid = wv;  wb_rd = wrd;  flush = fl;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic chk(input string nm, input longint b, input int p, input int e, input int r);
        exp_t x;
        x.name = nm;  x.busy = b;  x.pend = p;  x.err = e;  x.rdy = r;
        q.push_back(x);
    endtask

    initial begin
        idle();                                   chk("in_reset", 0, 0, 0, 1);
        idle(); reset = 1'b1;                     chk("post_reset", 0, 0, 0, 1);
        // RAW hazard on r5, released one cycle after its writeback edge
        drive(1, 5'd5, 1, 5'd0, 5'd0, 0, 5'd0, 0); chk("iss5", 0, 0, 0, 1);
        drive(1, 5'd0, 0, 5'd5, 5'd0, 0, 5'd0, 0); chk("raw_stall", 32'h20, 0, 0, 0);
        drive(1, 5'd0, 0, 5'd5, 5'd0, 1, 5'd5, 0); chk("wb_no_fwd", 32'h20, 1, 0, 0);
        drive(1, 5'd0, 0, 5'd5, 5'd0, 0, 5'd0, 0); chk("wb_release", 0, 1, 0, 1);
        idle();                                   chk("pend_lag", 0, 0, 0, -1);
        // Saturation at MAX_PEND on r7
        drive(1, 5'd7, 1, 5'd0, 5'd0, 0, 5'd0, 0); chk("r7_a", 0, 0, -1, 1);
        drive(1, 5'd7, 1, 5'd0, 5'd0, 0, 5'd0, 0); chk("r7_b", 32'h80, 0, -1, 1);
        drive(1, 5'd7, 1, 5'd0, 5'd0, 0, 5'd0, 0); chk("r7_c", 32'h80, 1, -1, 1);
        drive(1, 5'd7, 1, 5'd0, 5'd0, 0, 5'd0, 0); chk("max_block", 32'h80, 2, -1, 0);
        drive(1, 5'd7, 1, 5'd0, 5'd0, 1, 5'd7, 0); chk("max_wb_same", 32'h80, 3, -1, 0);
        drive(0, 5'd7, 1, 5'd0, 5'd0, 0, 5'd0, 0); chk("max_release", 32'h80, 3, -1, 1);
        idle();                                   chk("cnt7_two", 32'h80, 2, 0, 1);
        drive(0, 5'd0, 0, 5'd0, 5'd0, 1, 5'd7, 0); chk("drain7_a", 32'h80, 2, -1, -1);
        drive(0, 5'd0, 0, 5'd0, 5'd0, 1, 5'd7, 0); chk("drain7_b", 32'h80, 2, -1, -1);
        idle();                                   chk("drain7_c", 0, 1, 0, -1);
        // Same-cycle issue and writeback to r9 nets to zero
        drive(1, 5'd9, 1, 5'd0, 5'd0, 0, 5'd0, 0); chk("r9_iss", 0, 0, -1, 1);
        drive(1, 5'd9, 1, 5'd0, 5'd0, 1, 5'd9, 0); chk("r9_both", 32'h200, -1, -1, 1);
        idle();                                   chk("same_cycle_net0", 32'h200, 1, 0, -1);
        idle();                                   chk("r9_hold", 32'h200, 1, -1, -1);
        drive(0, 5'd0, 0, 5'd0, 5'd0, 1, 5'd9, 0); chk("r9_wb", 32'h200, 1, 0, -1);
        // Stray writebacks: r0 ignored, r12 sets the sticky error
        drive(0, 5'd0, 0, 5'd0, 5'd0, 1, 5'd0, 0); chk("wb0", 0, -1, 0, -1);
        idle();                                   chk("wb0_noerr", 0, -1, 0, -1);
        drive(0, 5'd0, 0, 5'd0, 5'd0, 1, 5'd12, 0); chk("wb12", 0, -1, 0, -1);
        drive(1, 5'd3, 1, 5'd0, 5'd0, 0, 5'd0, 0); chk("wb_err_set", 0, -1, 1, 1);
        drive(0, 5'd0, 0, 5'd0, 5'd0, 1, 5'd3, 0); chk("err_sticky_a", 32'h8, -1, 1, -1);
        idle();                                   chk("err_sticky_b", 0, -1, 1, -1);
        // Index zero never blocks and never counts
        drive(1, 5'd0, 1, 5'd0, 5'd0, 0, 5'd0, 0); chk("zero_a", 0, 0, 1, 1);
        drive(1, 5'd0, 1, 5'd0, 5'd0, 0, 5'd0, 0); chk("zero_b", 0, 0, 1, 1);
        idle();                                   chk("zero_c", 0, 0, 1, 1);
        // Build four pending writes, then flush against a concurrent issue
        drive(1, 5'd1, 1, 5'd0, 5'd0, 0, 5'd0, 0); chk("fill_1", 0, 0, -1, 1);
        drive(1, 5'd2, 1, 5'd0, 5'd0, 0, 5'd0, 0); chk("fill_2", 32'h2, -1, -1, 1);
        drive(1, 5'd4, 1, 5'd0, 5'd0, 0, 5'd0, 0); chk("fill_4", 32'h6, -1, -1, 1);
        drive(1, 5'd6, 1, 5'd0, 5'd0, 0, 5'd0, 0); chk("fill_6", 32'h16, -1, -1, 1);
        idle();                                   chk("fill_done", 32'h56, 3, 1, 1);
        drive(1, 5'd3, 1, 5'd0, 5'd0, 0, 5'd0, 1); chk("pend4_flush", 32'h56, 4, 1, 0);
        idle();                                   chk("flush_clear", 0, 0, 1, 1);
        idle();                                   chk("flush_after", 0, 0, 1, 1);
        // Asynchronous reset in the middle of traffic
        drive(1, 5'd10, 1, 5'd0, 5'd0, 0, 5'd0, 0); chk("pre_rst_a", 0, 0, 1, 1);
        drive(1, 5'd11, 1, 5'd0, 5'd0, 0, 5'd0, 0); chk("pre_rst_b", 32'h400, 0, 1, 1);
        drive(1, 5'd13, 1, 5'd0, 5'd0, 1, 5'd10, 0); reset = 1'b0;
        chk("reset_mid", 0, 0, 0, 1);
        drive(1, 5'd13, 1, 5'd0, 5'd0, 1, 5'd11, 0); chk("reset_hold", 0, 0, 0, 1);
        idle(); reset = 1'b1;                     chk("reset_release", 0, 0, 0, 1);
        idle();                                   chk("reset_idle", 0, 0, 0, 1);
        repeat (3) @(negedge clock);
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
